// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, widths and FSM states for the ALU accumulator sequencer
package alu_seq_pkg;

    localparam int WIDTH = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_DEC = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Only add and sub drive a meaningful overflow; everything else must be masked.
    function automatic logic op_has_ovf(input logic [2:0] m);
        return (m == OP_ADD) || (m == OP_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 4-bit combinational ALU driven by the accumulator sequencer
//
// Ports:
//   a, b      in  4  operands
//   m         in  3  mode (add, sub, cmp, and, or, not, inc, dec)
//   cin       in  1  carry-in for add
//   r         out 4  result; bit 3 is undefined for cmp
//   overflow  out 1  carry-out (add) / no-borrow (sub); undefined for other modes
module alu
    import alu_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] m,
    input  logic       cin,
    output logic [3:0] r,
    output logic       overflow
);

    logic [4:0] w_sum;
    logic [4:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        r        = 4'h0;
        // Undefined outputs carry junk so the consumer is forced to mask them.
        overflow = a[0] ^ b[3];
        case (m)
            OP_ADD: begin
                r        = w_sum[3:0];
                overflow = w_sum[4];
            end
            OP_SUB: begin
                r        = w_diff[3:0];
                overflow = ~w_diff[4];
            end
            OP_CMP: r = {a[3] ^ b[0], (a > b), (a == b), (a < b)};
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOT: r = ~a;
            OP_INC: r = a + 4'h1;
            OP_DEC: r = a - 4'h1;
            default: r = 4'h0;
        endcase
    end

endmodule

// File: rtl/alu_acc_sequencer.sv
// rtl/alu_acc_sequencer.sv - command sequencer and accumulator around the 4-bit ALU
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; fields cmd_op, cmd_operand, cmd_load
//   alu_a/alu_b/alu_m        registered ALU inputs (accumulator, operand, mode)
//   alu_r/alu_ovf            combinational ALU result and overflow
//   res_valid/res_ready      result handshake; fields res_data, res_ovf
//   acc                      current accumulator value
//   busy                     high whenever a command is in flight
module alu_acc_sequencer
    import alu_seq_pkg::*;
#(
    parameter int               WIDTH    = alu_seq_pkg::WIDTH,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic             cmd_load,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_m,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_m;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_ovf;

    logic             w_accept;
    logic [WIDTH-1:0] w_res_data;
    logic             w_res_ovf;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;

    // cmp only defines the three relation flags; the top bit is forced to zero.
    assign w_res_data = (r_alu_m == OP_CMP) ? {{(WIDTH-3){1'b0}}, alu_r[2:0]} : alu_r;
    assign w_res_ovf  = op_has_ovf(r_alu_m) ? alu_ovf : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_next = cmd_load ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: w_next = S_RESP;
            S_RESP: begin
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= ACC_INIT;
            r_alu_a    <= ACC_INIT;
            r_alu_b    <= '0;
            r_alu_m    <= 3'b000;
            r_res_data <= '0;
            r_res_ovf  <= 1'b0;
        end else if (w_accept) begin
            if (cmd_load) begin
                r_acc      <= cmd_operand;
                r_res_data <= cmd_operand;
                r_res_ovf  <= 1'b0;
            end else begin
                r_alu_a <= r_acc;
                r_alu_b <= cmd_operand;
                r_alu_m <= cmd_op;
            end
        end else if (r_state == S_EXEC) begin
            r_res_data <= w_res_data;
            r_res_ovf  <= w_res_ovf;
            if (r_alu_m != OP_CMP) begin
                r_acc <= w_res_data;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign res_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_m     = r_alu_m;
    assign res_data  = r_res_data;
    assign res_ovf   = r_res_ovf;
    assign acc       = r_acc;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// tb/tb_alu_acc_sequencer.sv - self-checking bench for alu_acc_sequencer with the ALU attached
module tb_alu_acc_sequencer;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_operand;
    logic       cmd_load;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_m;
    logic [3:0] alu_r;
    logic       alu_ovf;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_ovf;
    logic [3:0] acc;
    logic       busy;

    int n_checks;
    int n_fail;
    int m_acc;

    int         lat;
    logic [3:0] got_d;
    logic       got_o;

    alu u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .m        (alu_m),
        .cin      (1'b0),
        .r        (alu_r),
        .overflow (alu_ovf)
    );

    alu_acc_sequencer #(.WIDTH(4), .ACC_INIT(4'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .cmd_load    (cmd_load),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_m       (alu_m),
        .alu_r       (alu_r),
        .alu_ovf     (alu_ovf),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_ovf     (res_ovf),
        .acc         (acc),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic straight from the opcode definitions, result mod 16.
    function automatic logic [4:0] model(input logic [2:0] op, input int a, input int b);
        int d;
        bit o;
        o = 1'b0;
        case (op)
            3'd0: begin d = a + b; o = (d > 15); end
            3'd1: begin d = a - b; o = (a >= b); end
            3'd2: d = ((a > b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a < b) ? 1 : 0);
            3'd3: d = a & b;
            3'd4: d = a | b;
            3'd5: d = 15 - a;
            3'd6: d = a + 1;
            default: d = a - 1;
        endcase
        d = ((d % 16) + 16) % 16;
        return {o, d[3:0]};
    endfunction

    // Issues one command and completes its response; called at posedge+1.
    task automatic send(input bit ld, input logic [2:0] op, input logic [3:0] opnd);
        int w;
        cmd_valid   = 1'b1;
        cmd_load    = ld;
        cmd_op      = op;
        cmd_operand = opnd;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        cmd_load    = 1'($urandom_range(0, 1));
        cmd_op      = 3'($urandom_range(0, 7));
        cmd_operand = 4'($urandom_range(0, 15));
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got_d = res_data;
        got_o = res_ovf;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0;
        cmd_operand = 4'd0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        m_acc = 0;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (acc !== 4'h0) begin n_fail++; $display("FAIL reset_acc got %h want 0", acc); end
        n_checks++; if ({alu_a, alu_b, alu_m} !== 11'd0) begin n_fail++; $display("FAIL reset_alu_in got a=%h b=%h m=%h want 0", alu_a, alu_b, alu_m); end
        n_checks++; if ({res_data, res_ovf} !== 5'd0) begin n_fail++; $display("FAIL reset_res got %h/%b want 0/0", res_data, res_ovf); end
    endtask

    task automatic test_add();
        send(1'b1, OP_ADD, 4'h9);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL load_latency got %0d want 1", lat); end
        n_checks++; if ({got_d, got_o} !== {4'h9, 1'b0}) begin n_fail++; $display("FAIL load9 got %h/%b want 9/0", got_d, got_o); end
        send(1'b0, OP_ADD, 4'h8);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got %0d want 2", lat); end
        n_checks++; if ({got_d, got_o} !== {4'h1, 1'b1}) begin n_fail++; $display("FAIL add_9_8 got %h/%b want 1/1", got_d, got_o); end
        n_checks++; if (acc !== 4'h1) begin n_fail++; $display("FAIL add_acc got %h want 1", acc); end
        m_acc = 1;
    endtask

    task automatic test_sub();
        send(1'b1, OP_ADD, 4'h5);
        send(1'b0, OP_SUB, 4'h3);
        n_checks++; if ({got_d, got_o} !== {4'h2, 1'b1}) begin n_fail++; $display("FAIL sub_5_3 got %h/%b want 2/1", got_d, got_o); end
        send(1'b0, OP_SUB, 4'h7);
        n_checks++; if ({got_d, got_o} !== {4'hB, 1'b0}) begin n_fail++; $display("FAIL sub_2_7 got %h/%b want b/0", got_d, got_o); end
        n_checks++; if (acc !== 4'hB) begin n_fail++; $display("FAIL sub_acc got %h want b", acc); end
        m_acc = 11;
    endtask

    task automatic test_cmp();
        send(1'b1, OP_ADD, 4'h6);
        send(1'b0, OP_CMP, 4'h6);
        n_checks++; if ({got_d, got_o} !== {4'b0010, 1'b0}) begin n_fail++; $display("FAIL cmp_eq got %b/%b want 0010/0", got_d, got_o); end
        n_checks++; if (acc !== 4'h6) begin n_fail++; $display("FAIL cmp_acc got %h want 6", acc); end
        send(1'b0, OP_CMP, 4'h2);
        n_checks++; if ({got_d, got_o} !== {4'b0100, 1'b0}) begin n_fail++; $display("FAIL cmp_gt got %b/%b want 0100/0", got_d, got_o); end
        m_acc = 6;
    endtask

    task automatic test_wrap();
        send(1'b1, OP_ADD, 4'hF);
        send(1'b0, OP_INC, 4'h3);
        n_checks++; if ({got_d, got_o} !== {4'h0, 1'b0}) begin n_fail++; $display("FAIL inc_wrap got %h/%b want 0/0", got_d, got_o); end
        send(1'b0, OP_DEC, 4'h9);
        n_checks++; if ({got_d, got_o} !== {4'hF, 1'b0}) begin n_fail++; $display("FAIL dec_wrap got %h/%b want f/0", got_d, got_o); end
        send(1'b0, OP_NOT, 4'h1);
        n_checks++; if ({got_d, got_o} !== {4'h0, 1'b0}) begin n_fail++; $display("FAIL not_f got %h/%b want 0/0", got_d, got_o); end
        m_acc = 0;
    endtask

    task automatic test_backpressure();
        logic [3:0] d0;
        send(1'b1, OP_ADD, 4'h4);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD; cmd_operand = 4'h7;
        @(posedge clk); #1;
        cmd_operand = 4'h2;
        @(posedge clk); #1;
        d0 = res_data;
        n_checks++; if ({res_valid, d0} !== {1'b1, 4'hB}) begin n_fail++; $display("FAIL bp_first got v=%b d=%h want 1/b", res_valid, d0); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({res_valid, cmd_ready, res_data, acc} !== {1'b1, 1'b0, d0, 4'hB}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got v=%b rdy=%b d=%h acc=%h want 1/0/%h/b", i, res_valid, cmd_ready, res_data, acc, d0);
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_checks++; if ({res_valid, busy, acc} !== {1'b0, 1'b0, 4'hB}) begin n_fail++; $display("FAIL bp_release got v=%b busy=%b acc=%h want 0/0/b", res_valid, busy, acc); end
        m_acc = 11;
    endtask

    task automatic test_reset_mid();
        send(1'b1, OP_ADD, 4'h3);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD; cmd_operand = 4'h5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_exec got busy=%b want 1", busy); end
        rst_n = 1'b0;
        #2;
        n_checks++; if ({res_valid, busy, acc} !== {1'b0, 1'b0, 4'h0}) begin n_fail++; $display("FAIL rstmid_async got v=%b busy=%b acc=%h want 0/0/0", res_valid, busy, acc); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({res_valid, busy, acc} !== {1'b0, 1'b0, 4'h0}) begin
                n_fail++;
                $display("FAIL rstmid_after cycle %0d got v=%b busy=%b acc=%h want 0/0/0", i, res_valid, busy, acc);
            end
        end
        m_acc = 0;
    endtask

    task automatic test_random();
        bit         ld;
        logic [2:0] op;
        logic [3:0] b;
        logic [4:0] exp;
        int         exp_lat;
        for (int i = 0; i < 40; i++) begin
            ld = ($urandom_range(0, 3) == 0);
            op = 3'($urandom_range(0, 7));
            b  = 4'($urandom_range(0, 15));
            if (ld) begin
                exp = {1'b0, b};
                exp_lat = 1;
                m_acc = b;
            end else begin
                exp = model(op, m_acc, b);
                exp_lat = 2;
                if (op != OP_CMP) m_acc = exp[3:0];
            end
            send(ld, op, b);
            n_checks++;
            if ({got_o, got_d} !== exp || lat !== exp_lat || acc !== 4'(m_acc)) begin
                n_fail++;
                $display("FAIL rand %0d ld=%0d op=%0d b=%h got %h/%b lat %0d acc %h want %h/%b lat %0d acc %h",
                         i, ld, op, b, got_d, got_o, lat, acc, exp[3:0], exp[4], exp_lat, 4'(m_acc));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_sub();
        test_cmp();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
